// File: rtl/riscv_core_bp_pkg.sv
// Shared types for the branch predictor: counter encoding, BTB entry layout
// and the saturating counter update.
package riscv_core_bp_pkg;

  // Widest supported address; narrower cores zero-extend into these fields.
  localparam int BP_XLEN = 64;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic               valid;
    logic [BP_XLEN-1:0] tag;
    logic [BP_XLEN-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_WNT
  };

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken && ctr != CTR_ST) begin
      result = ctr + 2'd1;
    end else if (!taken && ctr != CTR_SNT) begin
      result = ctr - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/riscv_core_bp_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (fetch, execute)
// and one synchronous write or invalidate per cycle.
module riscv_core_bp_btb_table
  import riscv_core_bp_pkg::*;
#(
  parameter  int ENTRIES    = 16,
  localparam int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [INDEX_BITS-1:0] fetch_idx_i,
  output btb_entry_t            fetch_entry_o,
  input  logic [INDEX_BITS-1:0] ex_idx_i,
  output btb_entry_t            ex_entry_o,
  input  logic                  wr_en_i,
  input  logic                  inv_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  btb_entry_t            wr_entry_i
);

  btb_entry_t entry_q [ENTRIES];

  // Reads see only registered state, so a same-cycle write is not bypassed.
  assign fetch_entry_o = entry_q[fetch_idx_i];
  assign ex_entry_o    = entry_q[ex_idx_i];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= BTB_ENTRY_RESET;
      end
    end else if (wr_en_i) begin
      entry_q[wr_idx_i] <= wr_entry_i;
    end else if (inv_en_i) begin
      entry_q[wr_idx_i].valid <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_core_branch_predictor.sv
// Fetch-stage BTB prediction plus execute-stage resolution and training.
module riscv_core_branch_predictor
  import riscv_core_bp_pkg::*;
#(
  parameter  int ADDRLEN    = 64,
  parameter  int ENTRIES    = 16,
  localparam int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic               i_branch_predictor_clk,
  input  logic               i_branch_predictor_rst,
  input  logic [ADDRLEN-1:0] i_branch_predictor_fetch_pc,
  output logic               o_branch_predictor_valid,
  output logic               o_branch_predictor_isTaken,
  output logic [ADDRLEN-1:0] o_branch_predictor_predictedAddr,
  input  logic               i_branch_predictor_ex_valid,
  input  logic [ADDRLEN-1:0] i_branch_predictor_ex_pc,
  input  logic               i_branch_predictor_ex_is_branch,
  input  logic               i_branch_predictor_ex_is_compressed,
  input  logic               i_branch_predictor_ex_taken,
  input  logic [ADDRLEN-1:0] i_branch_predictor_ex_target,
  input  logic               i_branch_predictor_ex_pred_taken,
  input  logic [ADDRLEN-1:0] i_branch_predictor_ex_pred_addr,
  output logic               o_branch_predictor_misprediction,
  output logic [ADDRLEN-1:0] o_branch_predictor_recoveredAddr
);

  logic                  rst;
  logic [INDEX_BITS-1:0] fetch_idx, ex_idx;
  logic [BP_XLEN-1:0]    fetch_tag, ex_tag;
  btb_entry_t            fetch_entry, ex_entry, wr_entry;
  logic                  fetch_hit, ex_hit;
  logic                  wr_en, inv_en;
  logic [ADDRLEN-1:0]    ex_seq;
  logic                  unused_pc_lsb;

  assign rst = i_branch_predictor_rst;

  // Bit 0 of a PC is always zero, so index starts at bit 1.
  assign fetch_idx = i_branch_predictor_fetch_pc[INDEX_BITS:1];
  assign ex_idx    = i_branch_predictor_ex_pc[INDEX_BITS:1];
  assign fetch_tag = BP_XLEN'(i_branch_predictor_fetch_pc[ADDRLEN-1:INDEX_BITS+1]);
  assign ex_tag    = BP_XLEN'(i_branch_predictor_ex_pc[ADDRLEN-1:INDEX_BITS+1]);
  assign unused_pc_lsb = i_branch_predictor_fetch_pc[0] ^ i_branch_predictor_ex_pc[0];

  riscv_core_bp_btb_table #(
    .ENTRIES (ENTRIES)
  ) u_btb_table (
    .clk_i         (i_branch_predictor_clk),
    .srst_i        (rst),
    .fetch_idx_i   (fetch_idx),
    .fetch_entry_o (fetch_entry),
    .ex_idx_i      (ex_idx),
    .ex_entry_o    (ex_entry),
    .wr_en_i       (wr_en),
    .inv_en_i      (inv_en),
    .wr_idx_i      (ex_idx),
    .wr_entry_i    (wr_entry)
  );

  assign fetch_hit = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
  assign ex_hit    = ex_entry.valid && (ex_entry.tag == ex_tag);

  assign o_branch_predictor_valid         = fetch_hit && !rst;
  assign o_branch_predictor_isTaken       = o_branch_predictor_valid && fetch_entry.ctr[1];
  assign o_branch_predictor_predictedAddr = o_branch_predictor_valid ?
                                            ADDRLEN'(fetch_entry.target) : '0;

  assign ex_seq = i_branch_predictor_ex_pc +
                  (i_branch_predictor_ex_is_compressed ? ADDRLEN'(2) : ADDRLEN'(4));

  always_comb begin
    o_branch_predictor_misprediction = 1'b0;
    o_branch_predictor_recoveredAddr = '0;
    if (!rst && i_branch_predictor_ex_valid) begin
      if (i_branch_predictor_ex_is_branch) begin
        if (i_branch_predictor_ex_taken != i_branch_predictor_ex_pred_taken) begin
          o_branch_predictor_misprediction = 1'b1;
          o_branch_predictor_recoveredAddr = i_branch_predictor_ex_taken ?
                                             i_branch_predictor_ex_target : ex_seq;
        end else if (i_branch_predictor_ex_taken &&
                     i_branch_predictor_ex_target != i_branch_predictor_ex_pred_addr) begin
          o_branch_predictor_misprediction = 1'b1;
          o_branch_predictor_recoveredAddr = i_branch_predictor_ex_target;
        end
      end else if (i_branch_predictor_ex_pred_taken) begin
        // Fetch aliased a non-branch onto a BTB entry; resume sequentially.
        o_branch_predictor_misprediction = 1'b1;
        o_branch_predictor_recoveredAddr = ex_seq;
      end
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    inv_en   = 1'b0;
    wr_entry = ex_entry;
    if (i_branch_predictor_ex_valid) begin
      if (i_branch_predictor_ex_is_branch) begin
        if (ex_hit) begin
          wr_en        = 1'b1;
          wr_entry.ctr = ctr_update(ex_entry.ctr, i_branch_predictor_ex_taken);
          if (i_branch_predictor_ex_taken) begin
            wr_entry.target = BP_XLEN'(i_branch_predictor_ex_target);
          end
        end else if (i_branch_predictor_ex_taken) begin
          wr_en           = 1'b1;
          wr_entry.valid  = 1'b1;
          wr_entry.tag    = ex_tag;
          wr_entry.target = BP_XLEN'(i_branch_predictor_ex_target);
          wr_entry.ctr    = CTR_WT;
        end
      end else if (ex_hit) begin
        inv_en = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Directed and randomized checks of the branch predictor against an
// array-based reference of the BTB contents.
module tb_riscv_core_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IB      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fetch_pc;
  logic        p_valid, p_taken, mis;
  logic [63:0] p_addr, rec_addr;
  logic        ex_valid, ex_br, ex_c, ex_tk, ex_ptk;
  logic [63:0] ex_pc, ex_tgt, ex_paddr;

  always #5 clk = ~clk;

  riscv_core_branch_predictor #(.ADDRLEN(64), .ENTRIES(ENTRIES)) dut (
    .i_branch_predictor_clk              (clk),
    .i_branch_predictor_rst              (rst),
    .i_branch_predictor_fetch_pc         (fetch_pc),
    .o_branch_predictor_valid            (p_valid),
    .o_branch_predictor_isTaken          (p_taken),
    .o_branch_predictor_predictedAddr    (p_addr),
    .i_branch_predictor_ex_valid         (ex_valid),
    .i_branch_predictor_ex_pc            (ex_pc),
    .i_branch_predictor_ex_is_branch     (ex_br),
    .i_branch_predictor_ex_is_compressed (ex_c),
    .i_branch_predictor_ex_taken         (ex_tk),
    .i_branch_predictor_ex_target        (ex_tgt),
    .i_branch_predictor_ex_pred_taken    (ex_ptk),
    .i_branch_predictor_ex_pred_addr     (ex_paddr),
    .o_branch_predictor_misprediction    (mis),
    .o_branch_predictor_recoveredAddr    (rec_addr)
  );

  // Reference BTB: plain arrays, counter held as an integer 0..3.
  bit          m_valid [ENTRIES];
  logic [63:0] m_tag   [ENTRIES];
  logic [63:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  int checks = 0;
  int errors = 0;

  logic        obs_valid, obs_taken, obs_mis;
  logic [63:0] obs_addr, obs_rec;

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 1) % ENTRIES);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] pc);
    return pc >> (IB + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic mpred(input logic [63:0] pc, output bit v, output bit t, output logic [63:0] a);
    int i;
    i = idx_of(pc);
    v = m_valid[i] && (m_tag[i] == tag_of(pc));
    t = v && (m_ctr[i] >= 2);
    a = v ? m_tgt[i] : 64'd0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational outputs, advance the edge, update model.
  task automatic cyc(input bit r, input logic [63:0] fpc, input bit v, input logic [63:0] pc,
                     input bit br, input bit c, input bit tk, input logic [63:0] tgt,
                     input bit ptk, input logic [63:0] paddr);
    bit          ev, et, emis, hit;
    logic [63:0] ea, erec, seq;
    int          i;
    rst = r; fetch_pc = fpc; ex_valid = v; ex_pc = pc; ex_br = br; ex_c = c;
    ex_tk = tk; ex_tgt = tgt; ex_ptk = ptk; ex_paddr = paddr;
    #1;
    mpred(fpc, ev, et, ea);
    if (r) begin ev = 0; et = 0; ea = 0; end
    seq  = pc + (c ? 64'd2 : 64'd4);
    emis = 0; erec = 0;
    if (!r && v) begin
      if (br) begin
        if (tk != ptk) begin emis = 1; erec = tk ? tgt : seq; end
        else if (tk && tgt != paddr) begin emis = 1; erec = tgt; end
      end else if (ptk) begin
        emis = 1; erec = seq;
      end
    end
    obs_valid = p_valid; obs_taken = p_taken; obs_addr = p_addr;
    obs_mis = mis; obs_rec = rec_addr;
    chk("valid", 64'(p_valid), 64'(ev));
    chk("isTaken", 64'(p_taken), 64'(et));
    chk("predictedAddr", p_addr, ea);
    chk("misprediction", 64'(mis), 64'(emis));
    chk("recoveredAddr", rec_addr, erec);
    $display("cyc rst=%0d fpc=%h v=%0d/%0d/%h ex pc=%h br=%0d tk=%0d mis=%0d rec=%h",
             r, fpc, p_valid, p_taken, p_addr, pc, br, tk, mis, rec_addr);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (v) begin
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(pc));
      if (br) begin
        if (hit) begin
          m_ctr[i] = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
          if (tk) m_tgt[i] = tgt;
        end else if (tk) begin
          m_valid[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
        end
      end else if (hit) begin
        m_valid[i] = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] fpc, epc, tgt, paddr;
    bit          exv, br, c, tk, ptk, r, mv, mt;
    logic [63:0] ma;

    model_reset();
    @(negedge clk);
    cyc(1, 64'h1000, 1, 64'h1000, 1, 0, 1, 64'h2000, 0, 0);
    chk("reset_valid", 64'(obs_valid), 64'd0);
    chk("reset_mis", 64'(obs_mis), 64'd0);
    cyc(1, 64'h1000, 0, 0, 0, 0, 0, 0, 0, 0);

    // Cold miss, taken branch allocates.
    cyc(0, 64'h1000, 1, 64'h1000, 1, 0, 1, 64'h2000, 0, 0);
    chk("cold_valid", 64'(obs_valid), 64'd0);
    chk("alloc_mis", 64'(obs_mis), 64'd1);
    chk("alloc_rec", obs_rec, 64'h2000);
    cyc(0, 64'h1000, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hit_valid", 64'(obs_valid), 64'd1);
    chk("hit_taken", 64'(obs_taken), 64'd1);
    chk("hit_addr", obs_addr, 64'h2000);

    // Not-taken while fetching the same PC: old prediction still visible.
    cyc(0, 64'h1000, 1, 64'h1000, 1, 0, 0, 64'h2000, 1, 64'h2000);
    chk("bypass_old_taken", 64'(obs_taken), 64'd1);
    chk("nt_rec_seq", obs_rec, 64'h1004);
    cyc(0, 64'h1000, 1, 64'h1000, 1, 0, 0, 64'h2000, 0, 0);
    chk("wnt_taken", 64'(obs_taken), 64'd0);
    cyc(0, 64'h1000, 1, 64'h1000, 1, 0, 0, 64'h2000, 0, 0);
    cyc(0, 64'h1000, 1, 64'h1000, 1, 0, 1, 64'h2000, 0, 0);
    cyc(0, 64'h1000, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_low_taken", 64'(obs_taken), 64'd0);
    for (int k = 0; k < 3; k++) cyc(0, 64'h1000, 1, 64'h1000, 1, 0, 1, 64'h2000, 1, 64'h2000);
    cyc(0, 64'h1000, 1, 64'h1000, 1, 0, 0, 64'h2000, 1, 64'h2000);
    cyc(0, 64'h1000, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_high_taken", 64'(obs_taken), 64'd1);

    // Sequential recovery for compressed and full-width instructions.
    cyc(0, 64'h0, 1, 64'h1002, 1, 1, 0, 64'h3000, 1, 64'h3000);
    chk("rvc_rec", obs_rec, 64'h1004);
    cyc(0, 64'h0, 1, 64'h1002, 1, 0, 0, 64'h3000, 1, 64'h3000);
    chk("rv32_rec", obs_rec, 64'h1006);
    cyc(0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0, 64'h10, 1, 64'h10);
    chk("wrap_rec", obs_rec, 64'h0);

    // Target change on a taken jump.
    cyc(0, 64'h0, 1, 64'h1000, 1, 0, 1, 64'h3000, 1, 64'h2000);
    chk("jalr_mis", 64'(obs_mis), 64'd1);
    chk("jalr_rec", obs_rec, 64'h3000);
    cyc(0, 64'h1000, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("jalr_addr", obs_addr, 64'h3000);

    // Index conflict, then aliasing non-branch invalidates.
    cyc(0, 64'h0, 1, 64'h1020, 1, 0, 1, 64'h4000, 0, 0);
    cyc(0, 64'h1000, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("conflict_miss", 64'(obs_valid), 64'd0);
    cyc(0, 64'h1020, 1, 64'h1020, 0, 0, 0, 0, 1, 64'h4000);
    chk("alias_mis", 64'(obs_mis), 64'd1);
    chk("alias_rec", obs_rec, 64'h1024);
    cyc(0, 64'h1020, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alias_inval", 64'(obs_valid), 64'd0);

    // Reset beats a same-cycle training write.
    cyc(0, 64'h0, 1, 64'h1100, 1, 0, 1, 64'h5000, 0, 0);
    cyc(1, 64'h0, 1, 64'h1100, 1, 0, 1, 64'h6000, 0, 0);
    cyc(0, 64'h1100, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_wins", 64'(obs_valid), 64'd0);

    for (int n = 0; n < 1500; n++) begin
      epc = 64'h1000 + 64'($urandom_range(0, 63) << 1);
      fpc = ($urandom_range(0, 3) == 0) ? epc : 64'h1000 + 64'($urandom_range(0, 63) << 1);
      exv = ($urandom_range(0, 7) != 0);
      br  = ($urandom_range(0, 4) != 0);
      c   = 1'($urandom_range(0, 1));
      tk  = 1'($urandom_range(0, 1));
      tgt = 64'h8000 + 64'($urandom_range(0, 3)) * 4;
      mpred(epc, mv, mt, ma);
      if ($urandom_range(0, 2) != 0) begin
        ptk = mt; paddr = ma;
      end else begin
        ptk = 1'($urandom_range(0, 1)); paddr = 64'h8000 + 64'($urandom_range(0, 3)) * 4;
      end
      r = ($urandom_range(0, 99) == 0);
      cyc(r, fpc, exv, epc, br, c, tk, tgt, ptk, paddr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_core_branch_predictor.md
Name: riscv_core_branch_predictor

Overview:
- Supplies the next-PC selector with a prediction every fetch cycle: hit flag, taken flag and predicted target for the current fetch PC.
- Reads a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Resolves each branch/jump at execute: raises misprediction and the recovery address, and trains the table.
- Sits between the fetch PC register/next-PC selector and the execute-stage branch unit.

Parameters:
- ADDRLEN, 64, PC/address width.
- ENTRIES, 16, BTB entries; power of two, at least 2.
- INDEX_BITS, $clog2(ENTRIES), index width (derived, not overridden).

Ports:
- i_branch_predictor_clk  in  1  core clock; all state updates on rising edge.
- i_branch_predictor_rst  in  1  synchronous, active-high reset.
- i_branch_predictor_fetch_pc  in  ADDRLEN  current fetch PC.
- o_branch_predictor_valid  out  1  BTB hit for fetch_pc.
- o_branch_predictor_isTaken  out  1  predicted direction; equals counter[1] on hit, 0 on miss.
- o_branch_predictor_predictedAddr  out  ADDRLEN  stored target on hit, 0 on miss.
- i_branch_predictor_ex_valid  in  1  execute stage holds a valid instruction.
- i_branch_predictor_ex_pc  in  ADDRLEN  PC of the execute instruction.
- i_branch_predictor_ex_is_branch  in  1  instruction is a conditional branch or JAL/JALR.
- i_branch_predictor_ex_is_compressed  in  1  16-bit instruction (sequential step is 2, else 4).
- i_branch_predictor_ex_taken  in  1  actual outcome; 1 for jumps.
- i_branch_predictor_ex_target  in  ADDRLEN  actual target.
- i_branch_predictor_ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- i_branch_predictor_ex_pred_addr  in  ADDRLEN  predicted target carried down the pipe.
- o_branch_predictor_misprediction  out  1  flush and redirect request.
- o_branch_predictor_recoveredAddr  out  ADDRLEN  redirect address.

Behaviour:
- Address split:
  - idx = pc[INDEX_BITS:1], since PCs are 2-byte aligned.
  - tag = pc[ADDRLEN-1:INDEX_BITS+1].
- Entry contents: valid, tag, target[ADDRLEN-1:0], ctr[1:0].
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset: all entries invalid, ctr=01, tag and target=0. While reset is asserted the outputs are 0: valid, isTaken, predictedAddr, misprediction and recoveredAddr all read 0.
- Lookup:
  - Combinational from registered state, 0-cycle latency.
  - hit = entry[idx].valid & (entry[idx].tag == tag(fetch_pc)).
- Resolution (combinational from ex_* inputs), with seq = ex_pc + (ex_is_compressed ? 2 : 4) in ADDRLEN-bit wrapping arithmetic:
  - ex_valid=0: misprediction=0, recoveredAddr=0.
  - Branch, direction wrong (ex_taken != ex_pred_taken): misprediction=1, recoveredAddr = ex_taken ? ex_target : seq.
  - Branch, taken and predicted taken, ex_target != ex_pred_addr: misprediction=1, recoveredAddr=ex_target.
  - Non-branch with ex_pred_taken=1 (alias): misprediction=1, recoveredAddr=seq.
  - All other cases: misprediction=0, recoveredAddr=0.
- Training (registered, one write per cycle at edge; e = entry[idx(ex_pc)]):
  - Branch, hit:
    - ctr saturating +1 if taken, -1 if not taken; no wrap past 11 or 00.
    - If taken, target <= ex_target.
  - Branch, miss, taken: allocate (overwrite): valid=1, tag, target=ex_target, ctr=10.
  - Branch, miss, not taken: no write.
  - Non-branch that hits the BTB: valid <= 0.
- Same-cycle fetch lookup and training to the same index: the lookup returns the pre-update contents (no bypass). The new contents are visible the following cycle.
- Reset asserted in the same cycle as a training write: reset wins, and the write is discarded.

Decomposition:
- Package riscv_core_bp_pkg:
  - Counter encoding constants (SNT, WNT, WT, ST).
  - btb_entry_t struct typedef.
  - Function for saturating counter update.
- One sub-module, riscv_core_bp_btb_table: storage array with combinational read port and synchronous write/invalidate port.
- Resolution and training-control logic live in the top module.

Test Plan:
- Reset, then fetch_pc=0x1000 -> valid=0, isTaken=0, predictedAddr=0. Execute 0x1000 branch taken to 0x2000 -> misprediction=1, recoveredAddr=0x2000. Next cycle fetch 0x1000 -> valid=1, isTaken=1, predictedAddr=0x2000.
- Train 0x1000 not-taken twice from ctr=10 -> after first update isTaken=0 (ctr=01). After second, ctr=00; a third not-taken keeps ctr=00 (saturation). Four taken updates -> ctr=11, isTaken=1.
- Execute compressed branch at 0x1002 predicted taken, actually not taken -> misprediction=1, recoveredAddr=0x1004. Same with 32-bit instruction -> 0x1006.
- Taken JALR at 0x1000, pred_addr=0x2000, target=0x3000 -> misprediction=1, recoveredAddr=0x3000. Next fetch predictedAddr=0x3000.
- ENTRIES=16: train 0x1000, then 0x1020 (same index, different tag) -> fetch 0x1000 misses. Non-branch at 0x1020 predicted taken -> misprediction=1, recoveredAddr=0x1024, entry invalidated.
- Training write and fetch of the same PC in one cycle -> old prediction shown that cycle, new prediction the next. Reset asserted during training -> all lookups miss afterwards.
